// File: rtl/cmd_fifo_ring.sv
// cmd_fifo_ring: synchronous command FIFO between the host command decoder
// (producer) and the graphics command executor (consumer).
// Circular storage with wrap-bit pointers feeds a registered head stage
// (o_rd_data/o_rd_valid). The head stage counts toward capacity, so o_level
// covers both the array and the head.
// Optional build macro: CMDFIFO_PARITY_EN adds an even-parity bit per entry,
// which is checked as the entry loads into the head stage. A mismatch sets the
// sticky o_parity_err flag.
module cmd_fifo_ring #(
    parameter int PKT_BITS     = 32,
    parameter int DEPTH_BITS   = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                i_clk,
    input  logic                n_btn_rst,
    input  logic                i_flush,
    input  logic                i_wr_valid,
    input  logic [PKT_BITS-1:0] i_wr_data,
    output logic                o_wr_ready,
    output logic                o_rd_valid,
    output logic [PKT_BITS-1:0] o_rd_data,
    input  logic                i_rd_ready,
    output logic [DEPTH_BITS:0] o_level,
    output logic                o_almost_full,
    output logic                o_overflow,
    output logic                o_underflow
`ifdef CMDFIFO_PARITY_EN
    ,
    output logic                o_parity_err
`endif
);

    localparam int DEPTH = 2 ** DEPTH_BITS;
`ifdef CMDFIFO_PARITY_EN
    localparam int MEM_W = PKT_BITS + 1;
`else
    localparam int MEM_W = PKT_BITS;
`endif

    typedef logic [DEPTH_BITS:0] ptr_t;
    localparam ptr_t LVL_FULL  = ptr_t'(DEPTH);
    localparam ptr_t LVL_AFULL = ptr_t'(AFULL_THRESH);
    localparam ptr_t ONE       = ptr_t'(1);

    logic [MEM_W-1:0] mem [DEPTH];
    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    ptr_t             level_nxt;
    logic [MEM_W-1:0] wr_word;
    logic [MEM_W-1:0] head_word;
    logic             wr_acc;
    logic             rd_acc;
    logic             mem_empty;
    logic             head_load;

    // Handshake decode, head refill decision and next occupancy.
    // The head refills from the array only when the array held a word
    // before this edge. A word written on the same edge reaches the
    // head one edge later.
    always_comb begin
        wr_acc    = i_wr_valid && o_wr_ready;
        rd_acc    = i_rd_ready && o_rd_valid;
        mem_empty = (wr_ptr == rd_ptr);
        head_load = !mem_empty && (!o_rd_valid || rd_acc);
        head_word = mem[rd_ptr[DEPTH_BITS-1:0]];
`ifdef CMDFIFO_PARITY_EN
        wr_word   = {^i_wr_data, i_wr_data};
`else
        wr_word   = i_wr_data;
`endif
        level_nxt = o_level;
        if (wr_acc && !rd_acc) begin
            level_nxt = o_level + ONE;
        end else if (rd_acc && !wr_acc) begin
            level_nxt = o_level - ONE;
        end
    end

    // Storage array. It has no reset, so stale contents are simply overwritten.
    always_ff @(posedge i_clk) begin
        if (wr_acc && !i_flush) begin
            mem[wr_ptr[DEPTH_BITS-1:0]] <= wr_word;
        end
    end

    // Pointers, occupancy, status flags and head-valid.
    // o_wr_ready and o_almost_full come from the next level, so they
    // always agree with o_level.
    always_ff @(posedge i_clk or negedge n_btn_rst) begin
        if (!n_btn_rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            o_level       <= '0;
            o_wr_ready    <= 1'b1;
            o_almost_full <= 1'b0;
            o_overflow    <= 1'b0;
            o_underflow   <= 1'b0;
            o_rd_valid    <= 1'b0;
        end else if (i_flush) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            o_level       <= '0;
            o_wr_ready    <= 1'b1;
            o_almost_full <= 1'b0;
            o_overflow    <= 1'b0;
            o_underflow   <= 1'b0;
            o_rd_valid    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (head_load) begin
                rd_ptr <= rd_ptr + ONE;
            end
            o_level       <= level_nxt;
            o_wr_ready    <= (level_nxt != LVL_FULL);
            o_almost_full <= (level_nxt >= LVL_AFULL);
            if (i_wr_valid && !o_wr_ready) begin
                o_overflow <= 1'b1;
            end
            if (i_rd_ready && !o_rd_valid) begin
                o_underflow <= 1'b1;
            end
            if (head_load) begin
                o_rd_valid <= 1'b1;
            end else if (rd_acc) begin
                o_rd_valid <= 1'b0;
            end
        end
    end

    // Head data register. A flush leaves the last word in place.
    always_ff @(posedge i_clk or negedge n_btn_rst) begin
        if (!n_btn_rst) begin
            o_rd_data <= '0;
        end else if (!i_flush && head_load) begin
            o_rd_data <= head_word[PKT_BITS-1:0];
        end
    end

`ifdef CMDFIFO_PARITY_EN
    // Sticky parity error. The word is still delivered when the check fails.
    always_ff @(posedge i_clk or negedge n_btn_rst) begin
        if (!n_btn_rst) begin
            o_parity_err <= 1'b0;
        end else if (i_flush) begin
            o_parity_err <= 1'b0;
        end else if (head_load && (^head_word)) begin
            o_parity_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cmd_fifo_ring.sv
// tb_cmd_fifo_ring: scoreboard bench for cmd_fifo_ring. A queue-level model
// tracks occupancy, head visibility and the sticky flags. Each accepted write
// is pushed to a scoreboard queue. A monitor pops that queue whenever the DUT
// hands a word to the consumer.
module tb_cmd_fifo_ring;

    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        rd_ready = 1'b0;
    logic        o_wr_ready;
    logic        o_rd_valid;
    logic [31:0] o_rd_data;
    logic [4:0]  o_level;
    logic        o_almost_full;
    logic        o_overflow;
    logic        o_underflow;
`ifdef CMDFIFO_PARITY_EN
    logic        o_parity_err;
`endif

    cmd_fifo_ring #(.PKT_BITS(32), .DEPTH_BITS(4), .AFULL_THRESH(AFULL)) dut (
        .i_clk        (clk),
        .n_btn_rst    (rst_n),
        .i_flush      (flush),
        .i_wr_valid   (wr_valid),
        .i_wr_data    (wr_data),
        .o_wr_ready   (o_wr_ready),
        .o_rd_valid   (o_rd_valid),
        .o_rd_data    (o_rd_data),
        .i_rd_ready   (rd_ready),
        .o_level      (o_level),
        .o_almost_full(o_almost_full),
        .o_overflow   (o_overflow),
        .o_underflow  (o_underflow)
`ifdef CMDFIFO_PARITY_EN
        ,
        .o_parity_err (o_parity_err)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: total words held, whether a word is visible at the head, and the sticky flags.
    int          m_level = 0;
    bit          m_head  = 1'b0;
    bit          m_ovf   = 1'b0;
    bit          m_unf   = 1'b0;
    logic [31:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin : model
        bit wr_ok;
        bit rd_ok;
        int stored;
        if (!rst_n) begin
            m_level = 0; m_head = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
            exp_q.delete();
        end else if (flush) begin
            m_level = 0; m_head = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
            exp_q.delete();
        end else begin
            wr_ok  = wr_valid && (m_level != DEPTH);
            rd_ok  = rd_ready && m_head;
            stored = m_level - (m_head ? 1 : 0);
            if (wr_valid && !wr_ok) m_ovf = 1'b1;
            if (rd_ready && !m_head) m_unf = 1'b1;
            m_level = m_level + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
            m_head  = (m_head && !rd_ok) || (stored > 0);
            if (wr_ok) exp_q.push_back(wr_data);
        end
    end

    // Status check against the model, mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("level",       64'(o_level),       64'(m_level));
            chk("wr_ready",    64'(o_wr_ready),    64'(m_level != DEPTH));
            chk("almost_full", 64'(o_almost_full), 64'(m_level >= AFULL));
            chk("rd_valid",    64'(o_rd_valid),    64'(m_head));
            chk("overflow",    64'(o_overflow),    64'(m_ovf));
            chk("underflow",   64'(o_underflow),   64'(m_unf));
`ifdef CMDFIFO_PARITY_EN
            chk("parity_err",  64'(o_parity_err),  64'(0));
`endif
        end
    end

    // Monitor: a word about to be taken by the consumer must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && !flush && o_rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_nonempty", 64'(0), 64'(1));
            end else begin
                chk("rd_data", 64'(o_rd_data), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic step(input logic wv, input logic [31:0] wd, input logic rr, input logic fl);
        wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] nxt;
        logic        acc;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        // Fall-through latency with no reads pending.
        step(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
        chk("ft_not_yet", 64'(o_rd_valid), 64'(0));
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("ft_valid", 64'(o_rd_valid), 64'(1));
        chk("ft_data",  64'(o_rd_data),  64'(32'hA5A5_0001));
        chk("ft_level", 64'(o_level),    64'(1));
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Fill to capacity, then one write too many.
        for (int i = 0; i < 16; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        chk("fill_level", 64'(o_level), 64'(16));
        step(1'b1, 32'd16, 1'b0, 1'b0);
        chk("ovf_set", 64'(o_overflow), 64'(1));
        chk("ovf_level", 64'(o_level), 64'(16));

        // Streaming read and write from full; the producer holds the word until it is accepted.
        nxt = 32'd16;
        for (int i = 0; i < 40; i++) begin
            acc = o_wr_ready;
            step(1'b1, nxt, 1'b1, 1'b0);
            if (acc) nxt = nxt + 1;
        end
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Underflow, then a flush beats a simultaneous write.
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("unf_set", 64'(o_underflow), 64'(1));
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        chk("flush_unf",   64'(o_underflow), 64'(0));
        chk("flush_level", 64'(o_level),     64'(0));
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("flush_nowr",  64'(o_rd_valid),  64'(0));

        // Asynchronous reset at level 5.
        for (int i = 0; i < 5; i++) step(1'b1, 32'h5000 + 32'(i), 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_level", 64'(o_level), 64'(5));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rd_valid", 64'(o_rd_valid),    64'(0));
        chk("rst_rd_data",  64'(o_rd_data),     64'(0));
        chk("rst_level",    64'(o_level),       64'(0));
        chk("rst_wr_ready", 64'(o_wr_ready),    64'(1));
        chk("rst_afull",    64'(o_almost_full), 64'(0));
        chk("rst_ovf",      64'(o_overflow),    64'(0));
        chk("rst_unf",      64'(o_underflow),   64'(0));
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 32'hC0DE_0005, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("post_rst_valid", 64'(o_rd_valid), 64'(1));
        chk("post_rst_data",  64'(o_rd_data),  64'(32'hC0DE_0005));

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 59) == 0));
        end
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_level", 64'(o_level), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
